score_writer: RTL and testbench

SCORE_WRITER -- requirements
Module: score_writer

---
 rtl/score_pkg.sv | 26 ++
 rtl/score_writer_bcd_digit_add.sv | 21 ++
 rtl/score_writer.sv | 175 +++++++++++++++++
 tb/tb_score_writer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the score text writer.
// Optional feature macro: SCORE_EXTRA_LIFE_EN (extra life at 1000 points).
package score_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_D3,
      WR_D2,
      WR_D1,
      WR_D0,
      WR_LIV
   } state_t;

   localparam logic [7:0] SCORE_ADDR_BASE = 8'd7;
   localparam logic [7:0] LIVES_ADDR      = 8'd32;
   localparam logic [7:0] ASCII_ZERO      = 8'h30;

   localparam int PTS_PELLET = 10;
   localparam int PTS_POWER  = 50;
   localparam int PTS_GHOST  = 200;

   function automatic logic [7:0] digit_char(input logic [3:0] d);
      return ASCII_ZERO + {4'b0000, d};
   endfunction

endpackage

// File: rtl/score_writer_bcd_digit_add.sv
// One decimal digit of the BCD score adder.
// Optional feature macro: SCORE_EXTRA_LIFE_EN (not used here).
module bcd_digit_add (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [4:0] raw;
   logic [4:0] adj;

   always_comb begin
      raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
      adj  = raw - 5'd10;
      cout = (raw > 5'd9);
      sum  = cout ? adj[3:0] : raw[3:0];
   end

endmodule

// File: rtl/score_writer.sv
// BCD score/lives keeper that mirrors its values into the score text RAM.
// Optional feature macro: SCORE_EXTRA_LIFE_EN (one extra life at 1000 points).
module score_writer
   import score_pkg::*;
#(
   parameter int INIT_LIVES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pellet_eaten,
   input  logic        power_eaten,
   input  logic        ghost_eaten,
   input  logic        life_lost,
   output logic [7:0]  wr_data,
   output logic [7:0]  wr_addr,
   output logic        wr_en,
   output logic        busy,
   output logic [15:0] score_bcd,
   output logic [3:0]  lives,
   output logic        game_over
);

   state_t      state;
   state_t      state_nxt;
   logic        dirty;
   logic [15:0] snap_score;
   logic [3:0]  snap_lives;

   logic [15:0] add_bcd;
   logic [15:0] sum_bcd;
   logic [4:0]  carry;
   logic [15:0] score_nxt;
   logic [3:0]  lives_nxt;
   logic        lose;
   logic        bonus;
   logic        change;
   logic        take;

   // Per-cycle points expressed directly as BCD digits (max 260).
   always_comb begin
      add_bcd        = '0;
      add_bcd[7:4]   = (pellet_eaten ? 4'(PTS_PELLET / 10) : 4'd0)
                     + (power_eaten  ? 4'(PTS_POWER / 10)  : 4'd0);
      add_bcd[11:8]  = ghost_eaten ? 4'(PTS_GHOST / 100) : 4'd0;
   end

   assign carry[0] = 1'b0;

   for (genvar g = 0; g < 4; g++) begin : g_dig
      bcd_digit_add u_add (
         .a    (score_bcd[4*g +: 4]),
         .b    (add_bcd[4*g +: 4]),
         .cin  (carry[g]),
         .sum  (sum_bcd[4*g +: 4]),
         .cout (carry[g+1])
      );
   end

   assign score_nxt = carry[4] ? 16'h9999 : sum_bcd;
   assign lose      = life_lost && (lives != 4'd0);

`ifdef SCORE_EXTRA_LIFE_EN
   logic bonus_done;

   assign bonus = !bonus_done
               && (score_bcd[15:12] == 4'd0)
               && (score_nxt[15:12] != 4'd0);

   always_ff @(posedge clk) begin
      if (reset)
         bonus_done <= 1'b0;
      else if (bonus)
         bonus_done <= 1'b1;
   end
`else
   assign bonus = 1'b0;
`endif

   // A bonus and a lost life in one cycle cancel out.
   always_comb begin
      lives_nxt = lives;
      if (bonus && life_lost)
         lives_nxt = lives;
      else if (bonus && (lives < 4'd9))
         lives_nxt = lives + 4'd1;
      else if (lose)
         lives_nxt = lives - 4'd1;
   end

   assign change = (score_nxt != score_bcd)
                || (lives_nxt != lives)
                || bonus;
   assign take   = (state == IDLE) && dirty;

   always_ff @(posedge clk) begin
      if (reset) begin
         score_bcd  <= 16'h0000;
         lives      <= 4'(INIT_LIVES);
         dirty      <= 1'b1;
         snap_score <= 16'h0000;
         snap_lives <= 4'd0;
      end else begin
         score_bcd <= score_nxt;
         lives     <= lives_nxt;
         if (change)
            dirty <= 1'b1;
         else if (take)
            dirty <= 1'b0;
         if (take) begin
            snap_score <= score_bcd;
            snap_lives <= lives;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      wr_addr   = 8'd0;
      wr_data   = 8'd0;
      busy      = 1'b0;
      unique case (state)
         IDLE: begin
            if (dirty)
               state_nxt = WR_D3;
         end
         WR_D3: begin
            wr_en     = 1'b1;
            busy      = 1'b1;
            wr_addr   = SCORE_ADDR_BASE;
            wr_data   = digit_char(snap_score[15:12]);
            state_nxt = WR_D2;
         end
         WR_D2: begin
            wr_en     = 1'b1;
            busy      = 1'b1;
            wr_addr   = SCORE_ADDR_BASE + 8'd1;
            wr_data   = digit_char(snap_score[11:8]);
            state_nxt = WR_D1;
         end
         WR_D1: begin
            wr_en     = 1'b1;
            busy      = 1'b1;
            wr_addr   = SCORE_ADDR_BASE + 8'd2;
            wr_data   = digit_char(snap_score[7:4]);
            state_nxt = WR_D0;
         end
         WR_D0: begin
            wr_en     = 1'b1;
            busy      = 1'b1;
            wr_addr   = SCORE_ADDR_BASE + 8'd3;
            wr_data   = digit_char(snap_score[3:0]);
            state_nxt = WR_LIV;
         end
         WR_LIV: begin
            wr_en     = 1'b1;
            busy      = 1'b1;
            wr_addr   = LIVES_ADDR;
            wr_data   = digit_char(snap_lives);
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign game_over = (lives == 4'd0);

endmodule

// File: tb/tb_score_writer.sv
// Directed self-checking bench for score_writer.
// Honors SCORE_EXTRA_LIFE_EN when the design is built with it.
module tb_score_writer;

`ifdef SCORE_EXTRA_LIFE_EN
   localparam logic [3:0] BONUS_L = 4'd3;
`else
   localparam logic [3:0] BONUS_L = 4'd2;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pellet_eaten = 1'b0;
   logic        power_eaten = 1'b0;
   logic        ghost_eaten = 1'b0;
   logic        life_lost = 1'b0;
   logic [7:0]  wr_data;
   logic [7:0]  wr_addr;
   logic        wr_en;
   logic        busy;
   logic [15:0] score_bcd;
   logic [3:0]  lives;
   logic        game_over;

   int n_chk  = 0;
   int n_pass = 0;
   int lat;
   int cnt;

   score_writer #(.INIT_LIVES(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .pellet_eaten (pellet_eaten),
      .power_eaten  (power_eaten),
      .ghost_eaten  (ghost_eaten),
      .life_lost    (life_lost),
      .wr_data      (wr_data),
      .wr_addr      (wr_addr),
      .wr_en        (wr_en),
      .busy         (busy),
      .score_bcd    (score_bcd),
      .lives        (lives),
      .game_over    (game_over)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ev(input logic p, input logic w,
                     input logic g, input logic l);
      pellet_eaten = p;
      power_eaten  = w;
      ghost_eaten  = g;
      life_lost    = l;
      step();
      pellet_eaten = 1'b0;
      power_eaten  = 1'b0;
      ghost_eaten  = 1'b0;
      life_lost    = 1'b0;
   endtask

   task automatic drain();
      repeat (16) step();
   endtask

   task automatic wait_wr(output int c);
      c = 0;
      while (!wr_en && c < 20) begin
         step();
         c++;
      end
      if (!wr_en)
         chk("wr_timeout", 32'd0, 32'd1);
   endtask

   task automatic expect_wb(input logic [3:0] d3, input logic [3:0] d2,
                            input logic [3:0] d1, input logic [3:0] d0,
                            input logic [3:0] l, output int c);
      logic [3:0] d [4];
      d[0] = d3;
      d[1] = d2;
      d[2] = d1;
      d[3] = d0;
      wait_wr(c);
      for (int i = 0; i < 4; i++) begin
         chk("wb_en", 32'(wr_en), 32'd1);
         chk("wb_busy", 32'(busy), 32'd1);
         chk("wb_addr", 32'(wr_addr), 32'(7 + i));
         chk("wb_data", 32'(wr_data), 32'h30 + 32'(d[i]));
         step();
      end
      chk("wb_liv_addr", 32'(wr_addr), 32'd32);
      chk("wb_liv_data", 32'(wr_data), 32'h30 + 32'(l));
      step();
      chk("wb_idle_en", 32'(wr_en), 32'd0);
      chk("wb_idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      step();
      step();
      chk("rst_score", 32'(score_bcd), 32'h0000);
      chk("rst_lives", 32'(lives), 32'd2);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_addr", 32'(wr_addr), 32'd0);
      reset = 1'b0;
      expect_wb(4'd0, 4'd0, 4'd0, 4'd0, 4'd2, lat);
      chk("rst_wb_lat", 32'(lat), 32'd1);

      ev(1, 0, 0, 0);
      chk("pellet_score", 32'(score_bcd), 32'h0010);
      expect_wb(4'd0, 4'd0, 4'd1, 4'd0, 4'd2, lat);
      chk("pellet_lat", 32'(lat), 32'd1);

      // Reset aborts a sequence in flight.
      ev(1, 0, 0, 0);
      wait_wr(lat);
      step();
      step();
      reset = 1'b1;
      step();
      chk("abort_wr_en", 32'(wr_en), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_score", 32'(score_bcd), 32'h0000);
      reset = 1'b0;
      expect_wb(4'd0, 4'd0, 4'd0, 4'd0, 4'd2, lat);

      // Build 0990, then cross 1000 with a ghost.
      repeat (4) ev(0, 0, 1, 0);
      repeat (3) ev(0, 1, 0, 0);
      repeat (4) ev(1, 0, 0, 0);
      drain();
      chk("score_0990", 32'(score_bcd), 32'h0990);
      chk("lives_0990", 32'(lives), 32'd2);
      ev(0, 0, 1, 0);
      chk("score_1190", 32'(score_bcd), 32'h1190);
      chk("bonus_lives", 32'(lives), 32'(BONUS_L));
      expect_wb(4'd1, 4'd1, 4'd9, 4'd0, BONUS_L, lat);
      repeat (5) ev(0, 0, 1, 0);
      chk("score_2190", 32'(score_bcd), 32'h2190);
      chk("no_2nd_bonus", 32'(lives), 32'(BONUS_L));

      repeat (39) ev(0, 0, 1, 0);
      drain();
      chk("score_9990", 32'(score_bcd), 32'h9990);
      ev(1, 1, 1, 0);
      chk("score_sat", 32'(score_bcd), 32'h9999);
      expect_wb(4'd9, 4'd9, 4'd9, 4'd9, BONUS_L, lat);
      ev(1, 0, 0, 0);
      chk("score_hold", 32'(score_bcd), 32'h9999);

      // life_lost during the second write cycle.
      reset = 1'b1;
      step();
      reset = 1'b0;
      drain();
      ev(1, 0, 0, 0);
      wait_wr(lat);
      chk("ll_a7", 32'(wr_addr), 32'd7);
      step();
      chk("ll_a8", 32'(wr_addr), 32'd8);
      ev(0, 0, 0, 1);
      chk("ll_lives1", 32'(lives), 32'd1);
      chk("ll_a9", 32'(wr_addr), 32'd9);
      step();
      chk("ll_a10", 32'(wr_addr), 32'd10);
      step();
      chk("ll_a32", 32'(wr_addr), 32'd32);
      chk("ll_old_liv", 32'(wr_data), 32'h32);
      step();
      chk("ll_gap", 32'(wr_en), 32'd0);
      expect_wb(4'd0, 4'd0, 4'd1, 4'd0, 4'd1, lat);
      chk("ll_restart", 32'(lat), 32'd1);
      chk("go_low", 32'(game_over), 32'd0);

      ev(0, 0, 0, 1);
      chk("lives0", 32'(lives), 32'd0);
      chk("go_high", 32'(game_over), 32'd1);
      drain();
      ev(0, 0, 0, 1);
      chk("lives_floor", 32'(lives), 32'd0);
      cnt = 0;
      repeat (12) begin
         if (wr_en)
            cnt++;
         step();
      end
      chk("no_wb_dead", 32'(cnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
